// File: rtl/deferred_eq_pkg.sv
// Shared types and helpers for the deferred equality checker.
package deferred_eq_pkg;

    typedef enum logic [1:0] {
        MATCH = 2'd0,
        PEND  = 2'd1,
        FAIL  = 2'd2
    } chan_state_t;

    // Add without wrap: clamps at max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/deferred_eq_channel.sv
// One compared channel: mismatch persistence FSM with a single-cycle fail pulse.
module deferred_eq_channel #(
    parameter int WIDTH = 8,
    parameter int DEFER = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             report,
    output logic             fail
);
    import deferred_eq_pkg::*;

    localparam int RUN_W = $clog2(DEFER + 1);
    localparam logic [RUN_W-1:0] ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] LAST = RUN_W'(DEFER - 1);

    chan_state_t      state;
    logic [RUN_W-1:0] run;
    logic             neq;

    assign neq = (a != b);

    // Combinational "this sample completes the run" so the top can update
    // sticky/count/capture on the same edge that raises fail.
    assign report = en && neq &&
                    ((DEFER == 1) ? (state == MATCH)
                                  : (state == PEND && run == LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MATCH;
            run   <= '0;
            fail  <= 1'b0;
        end else begin
            fail <= report;
            if (en) begin
                case (state)
                    MATCH: if (neq) begin
                        run   <= ONE;
                        state <= (DEFER == 1) ? FAIL : PEND;
                    end
                    PEND: if (neq) begin
                        run <= run + ONE;
                        if (run == LAST) state <= FAIL;
                    end else begin
                        run   <= '0;
                        state <= MATCH;
                    end
                    FAIL: if (!neq) begin
                        run   <= '0;
                        state <= MATCH;
                    end
                    default: begin
                        run   <= '0;
                        state <= MATCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/deferred_eq_checker.sv
// Multi-channel deferred equality monitor: per-channel glitch filtering plus
// sticky flags, a saturating failure count and first-failure capture.
module deferred_eq_checker #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEFER    = 2,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic [CHANNELS-1:0]       fail,
    output logic [CHANNELS-1:0]       sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic                      first_valid,
    output logic [CH_W-1:0]           first_ch,
    output logic [WIDTH-1:0]          first_a,
    output logic [WIDTH-1:0]          first_b
);
    import deferred_eq_pkg::*;

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CHANNELS-1:0] report;
    logic [31:0]         pop;
    logic [CH_W-1:0]     pick_ch;
    logic [WIDTH-1:0]    pick_a;
    logic [WIDTH-1:0]    pick_b;
    logic [CHANNELS-1:0] sticky_base;
    logic [CNT_W-1:0]    cnt_base;
    logic                valid_base;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        deferred_eq_channel #(.WIDTH(WIDTH), .DEFER(DEFER)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .a      (a[g*WIDTH +: WIDTH]),
            .b      (b[g*WIDTH +: WIDTH]),
            .report (report[g]),
            .fail   (fail[g])
        );
    end

    // Popcount and lowest-index priority pick over this cycle's reports.
    always_comb begin
        pop     = '0;
        pick_ch = '0;
        pick_a  = a[0 +: WIDTH];
        pick_b  = b[0 +: WIDTH];
        for (int i = 0; i < CHANNELS; i++) pop = pop + 32'(report[i]);
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (report[i]) begin
                pick_ch = CH_W'(i);
                pick_a  = a[i*WIDTH +: WIDTH];
                pick_b  = b[i*WIDTH +: WIDTH];
            end
        end
    end

    // A same-cycle report is applied on top of the cleared values.
    assign sticky_base = clear ? '0   : sticky;
    assign cnt_base    = clear ? '0   : err_count;
    assign valid_base  = clear ? 1'b0 : first_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky      <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_a     <= '0;
            first_b     <= '0;
        end else begin
            sticky      <= sticky_base | report;
            err_count   <= CNT_W'(sat_add(32'(cnt_base), pop, CNT_MAX));
            first_valid <= valid_base | (|report);
            if (!valid_base && (|report)) begin
                first_ch <= pick_ch;
                first_a  <= pick_a;
                first_b  <= pick_b;
            end
        end
    end

endmodule

// File: tb/tb_deferred_eq_checker.sv
// Bench for deferred_eq_checker: vector table, directed corner sequences and
// randomized traffic checked against a run-length reference model.
module tb_deferred_eq_checker;

    localparam int W = 8;
    localparam int CH = 4;
    localparam int DEFER = 2;

    logic        clk, rst, en, clear;
    logic [31:0] a, b;
    logic [3:0]  fail, sticky, fail_s, sticky_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    logic        first_valid, first_valid_s;
    logic [1:0]  first_ch, first_ch_s;
    logic [7:0]  first_a, first_b, first_a_s, first_b_s;

    int total = 0;
    int bad = 0;

    deferred_eq_checker #(.WIDTH(W), .CHANNELS(CH), .DEFER(DEFER), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b),
        .fail(fail), .sticky(sticky), .err_count(err_count),
        .first_valid(first_valid), .first_ch(first_ch),
        .first_a(first_a), .first_b(first_b)
    );

    deferred_eq_checker #(.WIDTH(W), .CHANNELS(CH), .DEFER(DEFER), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b),
        .fail(fail_s), .sticky(sticky_s), .err_count(err_count_s),
        .first_valid(first_valid_s), .first_ch(first_ch_s),
        .first_a(first_a_s), .first_b(first_b_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count consecutive enabled mismatches per channel;
    // a report happens exactly when the count reaches DEFER.
    int         run_m[CH];
    logic [3:0] m_fail, m_sticky;
    int         m_cnt, m_cnt_s;
    logic       m_fv;
    logic [1:0] m_ch;
    logic [7:0] m_a, m_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic c,
                                input logic [31:0] va, input logic [31:0] vb);
        logic [3:0] rep;
        int n;
        if (r) begin
            for (int i = 0; i < CH; i++) run_m[i] = 0;
            m_fail = '0; m_sticky = '0; m_cnt = 0; m_cnt_s = 0;
            m_fv = 1'b0; m_ch = '0; m_a = '0; m_b = '0;
            return;
        end
        rep = '0;
        if (e) begin
            for (int i = 0; i < CH; i++) begin
                if (va[i*W +: W] != vb[i*W +: W]) begin
                    if (run_m[i] <= DEFER) run_m[i]++;
                    if (run_m[i] == DEFER) rep[i] = 1'b1;
                end else begin
                    run_m[i] = 0;
                end
            end
        end
        if (c) begin
            m_sticky = '0; m_cnt = 0; m_cnt_s = 0; m_fv = 1'b0;
        end
        n = $countones(rep);
        m_sticky = m_sticky | rep;
        m_cnt   = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        m_cnt_s = (m_cnt_s + n > 3) ? 3 : m_cnt_s + n;
        if (!m_fv && rep != 0) begin
            for (int i = CH - 1; i >= 0; i--) begin
                if (rep[i]) begin
                    m_ch = 2'(i); m_a = va[i*W +: W]; m_b = vb[i*W +: W];
                end
            end
            m_fv = 1'b1;
        end
        m_fail = rep;
    endtask

    task automatic compare_all();
        check("fail", 32'(fail), 32'(m_fail));
        check("sticky", 32'(sticky), 32'(m_sticky));
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("err_count_sat", 32'(err_count_s), 32'(m_cnt_s));
        check("first_valid", 32'(first_valid), 32'(m_fv));
        if (m_fv) begin
            check("first_ch", 32'(first_ch), 32'(m_ch));
            check("first_a", 32'(first_a), 32'(m_a));
            check("first_b", 32'(first_b), 32'(m_b));
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c,
                        input logic [31:0] va, input logic [31:0] vb);
        rst = r; en = e; clear = c; a = va; b = vb;
        @(posedge clk);
        model_update(r, e, c, va, vb);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] pk(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    typedef struct {
        logic        en;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_fail;
        logic [3:0]  exp_sticky;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] ga, gb, ca, cb, za, da, db, ea, eb;
        logic        r, e, c;
        logic [31:0] va, vb;

        ga = pk(8'h5A, 0, 0, 0);   gb = pk(8'h5B, 0, 0, 0);
        ca = pk(0, 0, 8'h10, 0);   cb = pk(0, 0, 8'h11, 0);
        da = pk(0, 8'h01, 0, 8'h03); db = pk(0, 8'h02, 0, 8'h04);
        ea = pk(0, 0, 0, 8'hC3);   eb = pk(0, 0, 0, 8'h3C);
        za = '0;

        tbl[0] = '{1'b1, ga, gb, 4'b0000, 4'b0000, 16'd0};
        tbl[1] = '{1'b1, za, za, 4'b0000, 4'b0000, 16'd0};
        tbl[2] = '{1'b1, za, za, 4'b0000, 4'b0000, 16'd0};
        tbl[3] = '{1'b1, ca, cb, 4'b0000, 4'b0000, 16'd0};
        tbl[4] = '{1'b1, ca, cb, 4'b0100, 4'b0100, 16'd1};
        tbl[5] = '{1'b1, ca, cb, 4'b0000, 4'b0100, 16'd1};
        tbl[6] = '{1'b1, ca, cb, 4'b0000, 4'b0100, 16'd1};
        tbl[7] = '{1'b1, ca, cb, 4'b0000, 4'b0100, 16'd1};
        tbl[8] = '{1'b1, za, za, 4'b0000, 4'b0100, 16'd1};

        for (int i = 0; i < CH; i++) run_m[i] = 0;
        m_fail = '0; m_sticky = '0; m_cnt = 0; m_cnt_s = 0;
        m_fv = 1'b0; m_ch = '0; m_a = '0; m_b = '0;

        step(1'b1, 1'b0, 1'b0, za, za);
        step(1'b0, 1'b1, 1'b0, za, za);

        // Glitch on ch0, then a held mismatch on ch2.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].en, 1'b0, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_fail", i), 32'(fail), 32'(tbl[i].exp_fail));
            check($sformatf("tbl%0d_sticky", i), 32'(sticky), 32'(tbl[i].exp_sticky));
            check($sformatf("tbl%0d_cnt", i), 32'(err_count), 32'(tbl[i].exp_cnt));
        end
        check("ch2_first_ch", 32'(first_ch), 32'd2);
        check("ch2_first_a", 32'(first_a), 32'h10);
        check("ch2_first_b", 32'(first_b), 32'h11);

        // ch1 and ch3 report together; lowest index is captured.
        step(1'b0, 1'b1, 1'b1, za, za);
        step(1'b0, 1'b1, 1'b0, da, db);
        step(1'b0, 1'b1, 1'b0, da, db);
        check("dual_fail", 32'(fail), 32'b1010);
        check("dual_cnt", 32'(err_count), 32'd2);
        check("dual_first_ch", 32'(first_ch), 32'd1);
        check("dual_first_a", 32'(first_a), 32'h01);
        step(1'b0, 1'b1, 1'b0, za, za);

        // en gap stretches latency without resetting the run.
        step(1'b0, 1'b1, 1'b1, za, za);
        step(1'b0, 1'b1, 1'b0, ga, gb);
        step(1'b0, 1'b0, 1'b0, ga, gb);
        check("engap_hold", 32'(fail), 32'b0000);
        step(1'b0, 1'b1, 1'b0, ga, gb);
        check("engap_fail", 32'(fail), 32'b0001);
        step(1'b0, 1'b1, 1'b0, za, za);

        // Reset mid-run discards it; the next run starts fresh.
        step(1'b0, 1'b1, 1'b0, ga, gb);
        step(1'b1, 1'b1, 1'b0, ga, gb);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        check("rst_valid", 32'(first_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, ga, gb);
        check("fresh_nofail", 32'(fail), 32'd0);
        step(1'b0, 1'b1, 1'b0, ga, gb);
        check("fresh_fail", 32'(fail), 32'b0001);
        step(1'b0, 1'b1, 1'b0, za, za);

        // Saturation of the narrow counter, then clear colliding with a report.
        step(1'b1, 1'b0, 1'b0, za, za);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, ga, gb);
            step(1'b0, 1'b1, 1'b0, ga, gb);
            step(1'b0, 1'b1, 1'b0, za, za);
        end
        check("sat_cnt_s", 32'(err_count_s), 32'd3);
        check("sat_cnt", 32'(err_count), 32'd5);
        step(1'b0, 1'b1, 1'b0, ea, eb);
        step(1'b0, 1'b1, 1'b1, ea, eb);
        check("clr_cnt_s", 32'(err_count_s), 32'd1);
        check("clr_sticky_s", 32'(sticky_s), 32'b1000);
        check("clr_first_ch", 32'(first_ch_s), 32'd3);
        check("clr_first_a", 32'(first_a_s), 32'hC3);
        check("clr_first_b", 32'(first_b_s), 32'h3C);
        step(1'b0, 1'b1, 1'b0, za, za);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 99) < 5);
            va = $urandom;
            vb = va;
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 99) < 45)
                    vb[i*W +: W] = va[i*W +: W] ^ 8'($urandom_range(1, 255));
            end
            step(r, e, c, va, vb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
